// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed
// access latency, byte/half/word accesses and misalignment/range checking.
//
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   req_valid_i       request presented by the initiator
//   req_ready_o       block can accept a request (only while idle)
//   req_write_i       1 = store, 0 = load
//   req_addr_i        byte address
//   req_wdata_i       store data, right-aligned
//   req_type_i        access size: 00 byte, 01 half, 10 word, 11 reserved
//   req_sign_i        load extension: 1 = sign, 0 = zero
//   resp_valid_o      response presented
//   resp_ready_i      initiator accepts the response
//   resp_rdata_o      load data (0 for stores and rejected requests)
//   resp_err_o        request was rejected
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [1:0]            req_type_i,
    input  logic                  req_sign_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o
);

    localparam int         IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] LAST  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                state;
    logic [3:0]            cnt;

    // Captured request fields
    logic                  write_q;
    logic                  sign_q;
    logic [1:0]            type_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-3:0] word_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  accept;
    logic                  commit;

    function automatic logic access_err(input logic [DATA_WIDTH-1:0] addr,
                                        input logic [1:0]            typ);
        logic                  e;
        logic [DATA_WIDTH-1:0] word_addr;
        word_addr = addr >> 2;
        case (typ)
            2'b00:   e = 1'b0;
            2'b01:   e = addr[0];
            2'b10:   e = |addr[1:0];
            default: e = 1'b1;
        endcase
        if (word_addr >= DATA_WIDTH'(MEM_WORDS)) e = 1'b1;
        return e;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [DATA_WIDTH-1:0] word,
                                                           input logic [1:0]            typ,
                                                           input logic [1:0]            off,
                                                           input logic                  sgn);
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (typ)
            2'b00:   r = {{(DATA_WIDTH-8){sgn & b[7]}}, b};
            2'b01:   r = {{(DATA_WIDTH-16){sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the byte lanes addressed by the store.
    function automatic logic [DATA_WIDTH-1:0] store_merge(input logic [DATA_WIDTH-1:0] old,
                                                          input logic [DATA_WIDTH-1:0] wdata,
                                                          input logic [1:0]            typ,
                                                          input logic [1:0]            off);
        logic [DATA_WIDTH-1:0] r;
        r = old;
        case (typ)
            2'b00: r[{off, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    assign accept  = req_valid_i && req_ready_o;
    assign mem_idx = IDX_W'(word_q);
    assign rd_word = mem[mem_idx];
    // Store commits on the edge that leaves BUSY; a reset during BUSY forces
    // IDLE immediately, so the pending store can never reach this edge.
    assign commit  = (state == BUSY) && (cnt == LAST) && write_q;

    // Request capture: datapath only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= req_write_i;
            sign_q  <= req_sign_i;
            type_q  <= req_type_i;
            off_q   <= req_addr_i[1:0];
            word_q  <= req_addr_i[DATA_WIDTH-1:2];
            wdata_q <= req_wdata_i;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[mem_idx] <= store_merge(rd_word, wdata_q, type_q, off_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready_o <= 1'b0;
                        cnt         <= 4'd0;
                        if (access_err(req_addr_i, req_type_i)) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == LAST) begin
                        state        <= RESP;
                        cnt          <= 4'd0;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= write_q ? '0 : load_extract(rd_word, type_q, off_q, sign_q);
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    // ready rises only after the handshake edge, so no new
                    // request can be taken in the completing cycle
                    if (resp_ready_i) begin
                        state        <= IDLE;
                        req_ready_o  <= 1'b1;
                        resp_valid_o <= 1'b0;
                        resp_rdata_o <= '0;
                        resp_err_o   <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder. A byte-array
// reference model predicts load data, error flags and response latency.
module tb_dmem_responder;

    localparam int DW  = 32;
    localparam int MW  = 1024;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_write_i = 1'b0;
    logic [DW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic [1:0]    req_type_i = 2'b00;
    logic          req_sign_i = 1'b0;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b0;
    logic [DW-1:0] resp_rdata_o;
    logic          resp_err_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_b [0:MW*4-1];

    dmem_responder #(.DATA_WIDTH(DW), .MEM_WORDS(MW), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_type_i   (req_type_i),
        .req_sign_i   (req_sign_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit model_err(input logic [31:0] a, input logic [1:0] t);
        int unsigned size;
        size = 1 << t;
        if (t == 2'b11) return 1'b1;
        if ((a % size) != 0) return 1'b1;
        if ((a / 4) >= MW) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] t, input logic s);
        int n;
        logic [31:0] v;
        n = 1 << t;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mem_b[a + i]) << (8 * i));
        if (s && n < 4 && v[8 * n - 1]) begin
            for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        int n;
        n = 1 << t;
        for (int i = 0; i < n; i++) mem_b[a + i] = d[8 * i +: 8];
    endtask

    // ---------------- driver ----------------
    // Issues one request, waits for its response and completes the handshake.
    // lat = cycles from the acceptance cycle to the first response cycle.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] t, input logic s,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd = '0;
        er = 1'b0;
        lat = -1;
        n = 0;
        @(negedge clk);
        while (req_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait: got %b required 1", req_ready_o);
            return;
        end
        req_valid_i = 1'b1;
        req_write_i = w;
        req_addr_i  = a;
        req_wdata_i = d;
        req_type_i  = t;
        req_sign_i  = s;
        @(posedge clk);
        #1;
        // scramble the request bus: captured fields must not follow it
        req_valid_i = 1'b0;
        req_write_i = 1'($urandom());
        req_addr_i  = $urandom();
        req_wdata_i = $urandom();
        req_type_i  = 2'($urandom());
        req_sign_i  = 1'($urandom());
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resp_valid_o !== 1'b1 && n < 40);
        checks++;
        if (resp_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL resp_valid_wait: got %b required 1", resp_valid_o);
            return;
        end
        lat = n;
        rd  = resp_rdata_o;
        er  = resp_err_o;
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        resp_ready_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_rdata_o !== 32'd0 || resp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                     req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, er, lat);
        model_store(32'h10, 32'hDEADBEEF, 2'b10);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            errors++;
            $display("FAIL word_store_resp: got rdata=%h err=%b required 00000000 0", rd, er);
        end
        checks++;
        if (lat != LAT + 1) begin
            errors++;
            $display("FAIL word_store_latency: got %0d required %0d", lat, LAT + 1);
        end
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL word_load: got rdata=%h err=%b required deadbeef 0", rd, er);
        end
        checks++;
        if (lat != LAT + 1) begin
            errors++;
            $display("FAIL word_load_latency: got %0d required %0d", lat, LAT + 1);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(1'b1, 32'h11, 32'hFFFFFF5A, 2'b00, 1'b0, rd, er, lat);
        model_store(32'h11, 32'hFFFFFF5A, 2'b00);
        do_req(1'b0, 32'h11, 32'h0, 2'b00, 1'b1, rd, er, lat);
        checks++;
        if (rd !== 32'h0000005A || er !== 1'b0) begin
            errors++;
            $display("FAIL byte_load_11: got %h required 0000005a", rd);
        end
        do_req(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFFFFDE) begin
            errors++;
            $display("FAIL byte_load_13_signed: got %h required ffffffde", rd);
        end
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD5AEF) begin
            errors++;
            $display("FAIL word_after_byte: got %h required dead5aef", rd);
        end
        do_req(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFFDEAD || er !== 1'b0) begin
            errors++;
            $display("FAIL half_load_signed: got %h required ffffdead", rd);
        end
        do_req(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 32'h0000DEAD) begin
            errors++;
            $display("FAIL half_load_unsigned: got %h required 0000dead", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er;
        int lat;
        logic        w_t [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] a_t [4]  = '{32'h12, 32'h13, 32'h10, 32'(MW * 4)};
        logic [1:0]  t_t [4]  = '{2'b10, 2'b01, 2'b11, 2'b10};
        do_req(1'b1, 32'h0, 32'h0BADF00D, 2'b10, 1'b0, rd, er, lat);
        model_store(32'h0, 32'h0BADF00D, 2'b10);
        for (int i = 0; i < 4; i++) begin
            do_req(w_t[i], a_t[i], 32'h11223344, t_t[i], 1'b1, rd, er, lat);
            checks++;
            if (er !== 1'b1 || rd !== 32'd0) begin
                errors++;
                $display("FAIL error_case_%0d: got err=%b rdata=%h required 1 00000000", i, er, rd);
            end
            checks++;
            if (lat != 1) begin
                errors++;
                $display("FAIL error_latency_%0d: got %0d required 1", i, lat);
            end
        end
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er, lat);
        checks++;
        if (rd !== model_load(32'h10, 2'b10, 1'b0)) begin
            errors++;
            $display("FAIL error_mem_10: got %h required %h", rd, model_load(32'h10, 2'b10, 1'b0));
        end
        do_req(1'b0, 32'h0, 32'h0, 2'b10, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL error_mem_00: got %h required 0badf00d", rd);
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] exp;
        exp = model_load(32'h10, 2'b10, 1'b0);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 32'h10;
        req_type_i  = 2'b10;
        req_sign_i  = 1'b0;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resp_valid_o !== 1'b1 && n < 40);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid_o !== 1'b1 || resp_rdata_o !== exp || req_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle_%0d: got valid=%b rdata=%h ready=%b required 1 %h 0",
                         i, resp_valid_o, resp_rdata_o, req_ready_o, exp);
            end
            @(negedge clk);
        end
        // handshake cycle: still no request acceptance possible
        resp_ready_i = 1'b1;
        req_valid_i  = 1'b1;
        req_addr_i   = 32'h0;
        #1;
        checks++;
        if (req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_handshake: got %b required 0", req_ready_o);
        end
        @(posedge clk);
        #1;
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b0;
        checks++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_handshake: got ready=%b valid=%b required 1 0", req_ready_o, resp_valid_o);
        end
    endtask

    task automatic test_reset_in_busy();
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, rd, er, lat);
        model_store(32'h20, 32'hCAFEF00D, 2'b10);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 32'h20;
        req_wdata_i = 32'h12345678;
        req_type_i  = 2'b10;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_rdata_o !== 32'd0 || resp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_reset_outputs: got ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                     req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        do_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er, lat);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL busy_reset_store_discarded: got %h required cafef00d", rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, exp;
        logic er, w, s, exp_err;
        logic [1:0] t;
        int lat, exp_lat;
        for (int i = 0; i < 32; i++) begin
            d = $urandom();
            do_req(1'b1, 32'(i * 4 + 64), d, 2'b10, 1'b0, rd, er, lat);
            model_store(32'(i * 4 + 64), d, 2'b10);
            checks++;
            if (er !== 1'b0 || rd !== 32'd0) begin
                errors++;
                $display("FAIL rand_init_%0d: got err=%b rdata=%h required 0 00000000", i, er, rd);
            end
        end
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) == 0) a = 32'(MW * 4) + $urandom_range(0, 255);
            else                           a = 32'($urandom_range(64, 191));
            t = 2'($urandom());
            w = 1'($urandom());
            s = 1'($urandom());
            d = $urandom();
            do_req(w, a, d, t, s, rd, er, lat);
            exp_err = model_err(a, t);
            exp = 32'd0;
            if (!exp_err) begin
                if (w) model_store(a, d, t);
                else   exp = model_load(a, t, s);
            end
            exp_lat = exp_err ? 1 : LAT + 1;
            checks++;
            if (er !== exp_err || rd !== exp || lat != exp_lat) begin
                errors++;
                $display("FAIL rand_op_%0d (w=%b a=%h t=%b s=%b): got err=%b rdata=%h lat=%0d required %b %h %0d",
                         i, w, a, t, s, er, rd, lat, exp_err, exp, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_half();
        test_errors();
        test_backpressure();
        test_reset_in_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data path and address width in bits.
REQ-002 Parameter MEM_WORDS, default 1024, SHALL set the storage depth in 32-bit words.
REQ-003 Parameter LATENCY, default 2, SHALL set the access delay in cycles, legal range 1..15.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 req_valid_i  input  1  SHALL flag a request presented by the initiator.
REQ-007 req_ready_o  output  1  SHALL flag that the block can accept a request.
REQ-008 req_write_i  input  1  SHALL select a store (1) or a load (0).
REQ-009 req_addr_i  input  DATA_WIDTH  SHALL carry the byte address.
REQ-010 req_wdata_i  input  DATA_WIDTH  SHALL carry the store data, right-aligned.
REQ-011 req_type_i  input  2  SHALL carry the access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-012 req_sign_i  input  1  SHALL select sign-extension (1) or zero-extension (0) on loads.
REQ-013 resp_valid_o  output  1  SHALL flag that a response is presented.
REQ-014 resp_ready_i  input  1  SHALL flag that the initiator accepts the response.
REQ-015 resp_rdata_o  output  DATA_WIDTH  SHALL carry the load data.
REQ-016 resp_err_o  output  1  SHALL flag that the request was rejected.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-018 req_ready_o SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid_i and req_ready_o are both 1 on a clock edge.
REQ-019 On acceptance, the block SHALL capture all request fields; inputs after acceptance SHALL be ignored until IDLE is re-entered.
REQ-020 Error condition: type 11; half with addr[0]=1; word with addr[1:0]!=00; or addr[31:2] >= MEM_WORDS.
REQ-021 A legal request SHALL move IDLE->BUSY; an error request SHALL move IDLE->RESP with no memory access.
REQ-022 BUSY SHALL last exactly LATENCY cycles, counted by a 4-bit counter, then move to RESP.
REQ-023 A store SHALL commit on the edge that leaves BUSY; only the addressed byte lanes SHALL change.
REQ-024 Byte lanes SHALL be little-endian: addr[1:0]=n selects bits 8n+7:8n; a half at addr[1]=1 uses bits 31:16.
REQ-025 Load data SHALL be the selected lanes shifted to bit 0 and extended to 32 bits as selected by req_sign_i.
REQ-026 Stores and error responses SHALL return resp_rdata_o=0; a legal access SHALL return resp_err_o=0.
REQ-027 In RESP, resp_valid_o SHALL be 1 and rdata/err SHALL be held stable until resp_ready_i=1, then the FSM SHALL move to IDLE.
REQ-028 A request SHALL NOT be accepted in the cycle in which a response completes; req_ready_o rises on the following cycle.
REQ-029 Minimum request-to-response latency SHALL be LATENCY+1 cycles for legal requests and 1 cycle for error requests.
REQ-030 A load to an address stored earlier SHALL return the stored data; requests are never reordered or overlapped.

Reset
REQ-031 While rst=0, the state SHALL be IDLE, the counter 0, req_ready_o=1 (asserted from reset), resp_valid_o=0, resp_rdata_o=0 and resp_err_o=0.
REQ-032 Reset asserted in BUSY before the commit edge SHALL discard the pending store, leaving memory unchanged.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-034 Word store 0xDEADBEEF @0x10, then word load @0x10 -> rdata 0xDEADBEEF, err 0; response exactly LATENCY+1 cycles after acceptance.
REQ-035 After REQ-034, byte store 0x5A @0x11 -> signed byte load @0x11 gives 0x0000005A; signed byte load @0x13 gives 0xFFFFFFDE; word load gives 0xDEAD5AEF.
REQ-036 After REQ-035, half load @0x12 -> signed 0xFFFFDEAD, unsigned 0x0000DEAD.
REQ-037 Word load @0x12, half load @0x13, type 11, and word @ MEM_WORDS*4 -> each gives err 1, rdata 0, response in 1 cycle, memory unchanged.
REQ-038 Response held for 5 cycles by resp_ready_i=0 -> rdata stable and req_ready_o=0 throughout; req_ready_o=1 the cycle after the handshake.
REQ-039 Pulse rst=0 during BUSY of a word store 0x12345678 @0x20 -> outputs reset immediately; a later load @0x20 returns the prior value.
